// File: rtl/dac_spi_rx.sv
// Serial DAC front end: receives 16-bit SPI frames into an input register and
// transfers that register to the DAC outputs while LDAC_n is held low.
module dac_spi_rx #(
    parameter int DATA_W  = 10,
    parameter int SCK_MIN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    input  logic              spi_ldac_n,
    output logic [DATA_W-1:0] dout,
    output logic              gain_x1,
    output logic              shdn_n,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              dout_upd,
    output logic              busy
);

    localparam int CS   = 3;
    localparam int SCK  = 2;
    localparam int SDI  = 1;
    localparam int LDAC = 0;
    localparam logic [3:0] PIN_IDLE = 4'b1001;
    // An SCK phase shorter than two clk can alias in the synchronizer.
    localparam bit SCK_OK = (SCK_MIN >= 2);

    typedef enum logic [1:0] {ST_UNARMED, ST_IDLE, ST_BUSY} state_t;

    state_t state, state_nxt;

    logic [3:0] pin_p0, pin_p1, pin_p2;
    logic       vld_p0, vld_p1;
    logic       cs_fall_p3, cs_rise_p3, cs_hi_p3, sck_rise_p3, sdi_p3, ldac_lo_p3;

    logic [4:0]        bit_cnt;
    logic [15:0]       shift_reg;
    logic [DATA_W-1:0] in_code;
    logic              in_ga, in_shdn;
    logic              start, load, reject;

    function automatic logic [4:0] cnt_sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    // Stage p0..p2: two-flop synchronizer plus delay flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_p0      <= PIN_IDLE;
            pin_p1      <= PIN_IDLE;
            pin_p2      <= PIN_IDLE;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            cs_fall_p3  <= 1'b0;
            cs_rise_p3  <= 1'b0;
            cs_hi_p3    <= 1'b0;
            sck_rise_p3 <= 1'b0;
            sdi_p3      <= 1'b0;
            ldac_lo_p3  <= 1'b0;
        end else begin
            pin_p0      <= {spi_cs_n, spi_sck, spi_sdi, spi_ldac_n};
            pin_p1      <= pin_p0;
            pin_p2      <= pin_p1;
            vld_p0      <= 1'b1;
            vld_p1      <= vld_p0;
            // Stage p3: registered events, acted on at the next edge
            cs_fall_p3  <= !pin_p1[CS] && pin_p2[CS];
            cs_rise_p3  <= pin_p1[CS] && !pin_p2[CS];
            cs_hi_p3    <= vld_p1 && pin_p1[CS];
            sck_rise_p3 <= SCK_OK && pin_p1[SCK] && !pin_p2[SCK];
            sdi_p3      <= pin_p1[SDI];
            ldac_lo_p3  <= !pin_p1[LDAC];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_UNARMED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        load      = 1'b0;
        reject    = 1'b0;
        case (state)
            // Only a genuinely sampled high cs_n arms; reset values never do.
            ST_UNARMED: if (cs_hi_p3) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (cs_fall_p3) begin
                    state_nxt = ST_BUSY;
                    start     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cs_rise_p3) begin
                    state_nxt = ST_IDLE;
                    if (bit_cnt == 5'd16 && !shift_reg[15]) load   = 1'b1;
                    else                                    reject = 1'b1;
                end
            end
            default: state_nxt = ST_UNARMED;
        endcase
    end

    assign busy = (state == ST_BUSY);

    // Stage p4: frame assembly, input register and output transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            in_code   <= '0;
            in_ga     <= 1'b1;
            in_shdn   <= 1'b0;
            dout      <= '0;
            gain_x1   <= 1'b1;
            shdn_n    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            dout_upd  <= 1'b0;
        end else begin
            frame_ok  <= load;
            frame_err <= reject;
            if (start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (busy && sck_rise_p3) begin
                shift_reg <= {shift_reg[14:0], sdi_p3};
                bit_cnt   <= cnt_sat_inc(bit_cnt);
            end
            if (load) begin
                in_code <= shift_reg[11 -: DATA_W];
                in_ga   <= shift_reg[13];
                in_shdn <= shift_reg[12];
            end
            // Transfer copies the pre-load register, so a coincident load lands one cycle later.
            if (ldac_lo_p3) begin
                dout     <= in_code;
                gain_x1  <= in_ga;
                shdn_n   <= in_shdn;
                dout_upd <= ({in_code, in_ga, in_shdn} != {dout, gain_x1, shdn_n});
            end else begin
                dout_upd <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: directed frame table, randomized frames against a
// frame-level reference model, and a reset-mid-frame sequence.
module tb_dac_spi_rx;

    localparam int DATA_W = 10;

    logic              tb_clk = 1'b0;
    logic              rst;
    logic              spi_cs_n, spi_sck, spi_sdi, spi_ldac_n;
    logic [DATA_W-1:0] dout;
    logic              gain_x1, shdn_n, frame_ok, frame_err, dout_upd, busy;

    always #5 tb_clk = ~tb_clk;

    dac_spi_rx #(.DATA_W(DATA_W), .SCK_MIN(3)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_ldac_n (spi_ldac_n),
        .dout       (dout),
        .gain_x1    (gain_x1),
        .shdn_n     (shdn_n),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .dout_upd   (dout_upd),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int ok_cnt = 0, err_cnt = 0, upd_cnt = 0, ok_cyc = -1, upd_cyc = -1;
    bit both_seen = 1'b0;

    // Pulse monitor, sampled 1 ns after each rising edge
    always @(posedge tb_clk) begin
        #1;
        cyc++;
        if (frame_ok)  begin ok_cnt++;  ok_cyc  = cyc; end
        if (frame_err) err_cnt++;
        if (dout_upd)  begin upd_cnt++; upd_cyc = cyc; end
        if (frame_ok && frame_err) both_seen = 1'b1;
    end

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          pre_sck;
        bit          ldac_hold;
        int          e_ok;
        int          e_err;
        logic [31:0] e_dout;
        logic        e_gain;
        logic        e_shdn;
        int          e_upd;
    } vec_t;

    vec_t vt[6];

    logic [DATA_W-1:0] m_code, m_dout;
    logic              m_ga, m_shdn, m_gain, m_sh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic clr_mon();
        ok_cnt = 0; err_cnt = 0; upd_cnt = 0;
        ok_cyc = -1; upd_cyc = -1; both_seen = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            spi_sdi = w[i];
            clk_wait(4);
            spi_sck = 1'b1;
            clk_wait(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits);
        spi_cs_n = 1'b0;
        spi_bits(w, nbits - 1, 0);
        clk_wait(4);
        spi_cs_n = 1'b1;
        clk_wait(10);
    endtask

    task automatic ldac_pulse();
        spi_ldac_n = 1'b0;
        clk_wait(4);
        spi_ldac_n = 1'b1;
        clk_wait(8);
    endtask

    task automatic sck_toggles(input int n);
        for (int i = 0; i < n; i++) begin
            spi_sck = 1'b1; clk_wait(4);
            spi_sck = 1'b0; clk_wait(4);
        end
    endtask

    task automatic check_outputs(input string tag, input int e_ok, input int e_err,
                                 input logic [31:0] e_dout, input logic e_gain,
                                 input logic e_shdn, input int e_upd);
        chk({tag, ".frame_ok"},  32'(ok_cnt),    32'(e_ok));
        chk({tag, ".frame_err"}, 32'(err_cnt),   32'(e_err));
        chk({tag, ".both"},      32'(both_seen), 32'd0);
        chk({tag, ".dout"},      32'(dout),      e_dout);
        chk({tag, ".gain_x1"},   32'(gain_x1),   32'(e_gain));
        chk({tag, ".shdn_n"},    32'(shdn_n),    32'(e_shdn));
        chk({tag, ".dout_upd"},  32'(upd_cnt),   32'(e_upd));
        chk({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clr_mon();
        if (v.pre_sck > 0) sck_toggles(v.pre_sck);
        if (v.ldac_hold) begin
            spi_ldac_n = 1'b0;
            clk_wait(2);
            send_frame(v.word, v.nbits);
            clk_wait(4);
            spi_ldac_n = 1'b1;
            clk_wait(8);
            chk({tag, ".upd_lag"}, 32'(upd_cyc - ok_cyc), 32'd1);
        end else begin
            send_frame(v.word, v.nbits);
            ldac_pulse();
        end
        check_outputs(tag, v.e_ok, v.e_err, v.e_dout, v.e_gain, v.e_shdn, v.e_upd);
    endtask

    initial begin
        vt[0] = '{32'h36B8,  16, 0, 1'b0, 1, 0, 32'h1AE, 1'b1, 1'b1, 1};
        vt[1] = '{32'h3C14,  16, 0, 1'b1, 1, 0, 32'h305, 1'b1, 1'b1, 1};
        vt[2] = '{32'hB6B8,  16, 0, 1'b0, 0, 1, 32'h305, 1'b1, 1'b1, 0};
        vt[3] = '{32'h1B5C,  15, 0, 1'b0, 0, 1, 32'h305, 1'b1, 1'b1, 0};
        vt[4] = '{32'h06D70, 17, 0, 1'b0, 0, 1, 32'h305, 1'b1, 1'b1, 0};
        vt[5] = '{32'h2000,  16, 5, 1'b0, 1, 0, 32'h000, 1'b1, 1'b0, 1};

        rst = 1'b1;
        spi_cs_n = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0; spi_ldac_n = 1'b1;
        clk_wait(5);
        chk("reset.dout",      32'(dout),      32'd0);
        chk("reset.gain_x1",   32'(gain_x1),   32'd1);
        chk("reset.shdn_n",    32'(shdn_n),    32'd0);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.pulses",    32'({frame_ok, frame_err, dout_upd}), 32'd0);
        rst = 1'b0;
        clk_wait(6);

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("dir%0d", i));

        // Reference model state after the directed table
        m_code = '0; m_ga = 1'b1; m_shdn = 1'b0;
        m_dout = '0; m_gain = 1'b1; m_sh = 1'b0;

        for (int n = 0; n < 30; n++) begin
            logic [31:0] w;
            int          nb, r, e_upd;
            bit          acc;
            r  = int'($urandom_range(0, 5));
            nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            w  = $urandom & ((32'd1 << nb) - 32'd1);
            if (nb == 16 && $urandom_range(0, 2) != 0) w[15] = 1'b0;
            acc = (nb == 16) && !w[15];
            if (acc) begin
                m_code = w[11 -: DATA_W];
                m_ga   = w[13];
                m_shdn = w[12];
            end
            e_upd  = ({m_code, m_ga, m_shdn} != {m_dout, m_gain, m_sh}) ? 1 : 0;
            m_dout = m_code; m_gain = m_ga; m_sh = m_shdn;
            clr_mon();
            if ($urandom_range(0, 3) == 0) sck_toggles(int'($urandom_range(1, 3)));
            send_frame(w, nb);
            ldac_pulse();
            check_outputs($sformatf("rnd%0d", n), acc ? 1 : 0, acc ? 0 : 1,
                          32'(m_dout), m_gain, m_sh, e_upd);
        end

        // Reset in the middle of a frame with cs_n held low across release
        clr_mon();
        spi_cs_n = 1'b0;
        spi_bits(32'h36B8, 15, 8);
        clk_wait(4);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        clk_wait(4);
        chk("midrst.dout_in_rst", 32'(dout), 32'd0);
        rst = 1'b0;
        clk_wait(2);
        spi_bits(32'h36B8, 7, 0);
        clk_wait(4);
        spi_cs_n = 1'b1;
        clk_wait(10);
        check_outputs("midrst", 0, 0, 32'd0, 1'b1, 1'b0, 0);
        clr_mon();
        ldac_pulse();
        check_outputs("midrst_ldac", 0, 0, 32'd0, 1'b1, 1'b0, 0);
        run_vec(vt[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
